// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg
// Shared definitions for the two-requester flash read arbiter: default
// widths and timing constants, the arbiter state encoding and the owner
// encoding used by the top level and the round-robin picker.
// The timeout default only exists when FLASH_ARB_TIMEOUT_EN is defined.
package flash_arb_pkg;

  localparam int ADDR_W_DEF  = 24;
  localparam int LEN_W_DEF   = 8;
  localparam int QUIET_DEF   = 64;
`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int TIMEOUT_DEF = 255;
`endif

  typedef enum logic [1:0] {
    ST_QUIET,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } arb_state_t;

  localparam logic OWNER_0 = 1'b0;
  localparam logic OWNER_1 = 1'b1;

endpackage

// File: rtl/flash_read_arbiter_if.sv
// flash_read_arbiter_if
// Byte-wide flash reader handshake shared by the arbiter and the reader.
//   fl_read  : one-cycle start pulse (arbiter -> reader)
//   fl_addr  : byte address, stable from fl_read until fl_ready
//   fl_ready : one-cycle byte-complete pulse (reader -> arbiter)
//   fl_data  : returned byte, valid with fl_ready
// Modports: master = arbiter side, slave = reader side.
interface flash_read_arbiter_if
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              fl_read;
  logic [ADDR_W-1:0] fl_addr;
  logic              fl_ready;
  logic [7:0]        fl_data;

  modport master (output fl_read, output fl_addr, input fl_ready, input fl_data);
  modport slave  (input fl_read, input fl_addr, output fl_ready, output fl_data);

endinterface

// File: rtl/flash_arb_rr2.sv
// flash_arb_rr2
// Two-way round-robin picker, purely combinational.
//   valid      : request levels, bit 0 = requester 0, bit 1 = requester 1
//   last_owner : requester served most recently (pointer held by the parent)
//   grant      : one-hot grant, 2'b00 when nobody requests
module flash_arb_rr2
  import flash_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic [1:0] grant
);

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_owner == OWNER_1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter
// Shares one byte-wide flash reader between two burst requesters.
// Grants round-robin, issues one reader transaction per byte with an
// auto-incrementing (wrapping) address and returns bytes on a shared bus.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid/addr/len, reqN_ack : burst request (len = bytes-1), capture pulse
//   rd_data, rd_valid0/1          : returned byte and owner strobe
//   done0/1, err0/1               : end-of-burst and timeout-abort pulses
//   busy                          : high from grant until done
//   fl                            : reader handshake (master modport)
// Optional: define FLASH_ARB_TIMEOUT_EN to abort a burst whose reader
// transaction does not complete within TIMEOUT cycles (err pulse).
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int QUIET   = QUIET_DEF
`ifdef FLASH_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ack,
  output logic [7:0]        rd_data,
  output logic              rd_valid0,
  output logic              rd_valid1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  flash_read_arbiter_if.master fl
);

  localparam int QW = $clog2(QUIET + 1);

  arb_state_t        state, state_n;
  logic [QW-1:0]     quiet_cnt, quiet_cnt_n;
  logic [ADDR_W-1:0] cur_addr, cur_addr_n;
  logic [LEN_W-1:0]  remain, remain_n;
  logic              owner, owner_n;
  logic              rr_ptr, rr_ptr_n;
  logic [ADDR_W-1:0] fl_addr_r, fl_addr_n;
  logic              fl_read_r, fl_read_n;
  logic              req0_ack_n, req1_ack_n;
  logic [7:0]        rd_data_n;
  logic              rd_valid0_n, rd_valid1_n;
  logic              done0_n, done1_n;
  logic              busy_n;
  logic [1:0]        grant;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt, wait_cnt_n;
  logic          err0_n, err1_n;
`endif

  // rr_ptr names the requester favoured on a tie; the picker wants the
  // requester served last, which is the other one.
  flash_arb_rr2 u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_owner (~rr_ptr),
    .grant      (grant)
  );

  assign fl.fl_read = fl_read_r;
  assign fl.fl_addr = fl_addr_r;

  // Next-state and next-output logic. Every output is registered, so the
  // pulses seen during ISSUE are computed on the transition into it.
  always_comb begin
    state_n     = state;
    quiet_cnt_n = quiet_cnt;
    cur_addr_n  = cur_addr;
    remain_n    = remain;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    fl_addr_n   = fl_addr_r;
    rd_data_n   = rd_data;
    busy_n      = busy;
    fl_read_n   = 1'b0;
    req0_ack_n  = 1'b0;
    req1_ack_n  = 1'b0;
    rd_valid0_n = 1'b0;
    rd_valid1_n = 1'b0;
    done0_n     = 1'b0;
    done1_n     = 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
    wait_cnt_n  = wait_cnt;
    err0_n      = 1'b0;
    err1_n      = 1'b0;
`endif
    case (state)
      ST_QUIET: begin
        // Lets any reader transaction left over from before reset drain.
        if (quiet_cnt == '0) begin
          state_n = ST_IDLE;
        end else begin
          quiet_cnt_n = quiet_cnt - 1'b1;
        end
      end
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_n    = grant[1] ? OWNER_1 : OWNER_0;
          cur_addr_n = grant[1] ? req1_addr : req0_addr;
          remain_n   = grant[1] ? req1_len : req0_len;
          fl_addr_n  = cur_addr_n;
          fl_read_n  = 1'b1;
          req0_ack_n = grant[0];
          req1_ack_n = grant[1];
          busy_n     = 1'b1;
          state_n    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
`ifdef FLASH_ARB_TIMEOUT_EN
        wait_cnt_n = '0;
`endif
      end
      ST_WAIT: begin
        if (fl.fl_ready) begin
          rd_data_n   = fl.fl_data;
          rd_valid0_n = (owner == OWNER_0);
          rd_valid1_n = (owner == OWNER_1);
          if (remain == '0) begin
            done0_n  = (owner == OWNER_0);
            done1_n  = (owner == OWNER_1);
            busy_n   = 1'b0;
            rr_ptr_n = ~owner;
            state_n  = ST_IDLE;
          end else begin
            // Next byte issues in the same cycle its predecessor is returned.
            cur_addr_n = cur_addr + 1'b1;
            remain_n   = remain - 1'b1;
            fl_addr_n  = cur_addr_n;
            fl_read_n  = 1'b1;
            state_n    = ST_ISSUE;
          end
        end
`ifdef FLASH_ARB_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT)) begin
          // Abort through QUIET so the stuck reader can finish unobserved.
          err0_n      = (owner == OWNER_0);
          err1_n      = (owner == OWNER_1);
          done0_n     = (owner == OWNER_0);
          done1_n     = (owner == OWNER_1);
          busy_n      = 1'b0;
          rr_ptr_n    = ~owner;
          quiet_cnt_n = QW'(QUIET);
          state_n     = ST_QUIET;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
`endif
      end
      default: state_n = ST_QUIET;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_QUIET;
      quiet_cnt <= QW'(QUIET);
      cur_addr  <= '0;
      remain    <= '0;
      owner     <= OWNER_0;
      rr_ptr    <= OWNER_0;
      fl_addr_r <= '0;
      fl_read_r <= 1'b0;
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      rd_data   <= 8'h00;
      rd_valid0 <= 1'b0;
      rd_valid1 <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      quiet_cnt <= quiet_cnt_n;
      cur_addr  <= cur_addr_n;
      remain    <= remain_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      fl_addr_r <= fl_addr_n;
      fl_read_r <= fl_read_n;
      req0_ack  <= req0_ack_n;
      req1_ack  <= req1_ack_n;
      rd_data   <= rd_data_n;
      rd_valid0 <= rd_valid0_n;
      rd_valid1 <= rd_valid1_n;
      done0     <= done0_n;
      done1     <= done1_n;
      busy      <= busy_n;
    end
  end

`ifdef FLASH_ARB_TIMEOUT_EN
  // Timeout counter and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err0     <= 1'b0;
      err1     <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_n;
      err0     <= err0_n;
      err1     <= err1_n;
    end
  end
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule
